// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: data word, ALU opcode encoding and sizing limits.
package alu_arbiter_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned OP_W            = 3;
   localparam int unsigned ALU_ARB_MAX_REQ = 8;

   typedef logic [DATA_W-1:0] Data;

   // Encoding 3'b111 is left undefined and yields a zero result.
   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_SLT  = 3'd5,
      ALU_SLTU = 3'd6
   } AluOp;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by all requesters; arithmetic wraps modulo 2^DATA_W.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic [OP_W-1:0]   op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o
);

   always_comb begin
      result_o = '0;
      case (AluOp'(op_i))
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SLT:  result_o = DATA_W'($signed(a_i) < $signed(b_i));
         ALU_SLTU: result_o = DATA_W'(a_i < b_i);
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first eligible index at or after ptr (wrapping) wins.
module alu_arbiter_rr_picker #(
   parameter  int unsigned N     = 2,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o
);

   int unsigned      sum;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      sum     = 0;
      cand    = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         sum = 32'(ptr_i) + i;
         if (sum >= N) sum = sum - N;
         cand = IDX_W'(sum);
         if (!found && eligible_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grant and one
// registered result slot per requester (1-cycle accept-to-response latency).
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*OP_W-1:0]   i_req_op,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_operandA,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_operandB,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic [NUM_REQ-1:0]        o_rsp_valid,
   output logic [NUM_REQ*DATA_W-1:0] o_rsp_result,
   input  logic [NUM_REQ-1:0]        i_rsp_ready
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ*DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic [IDX_W-1:0]          ptr_q, ptr_d;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               accept;
   logic [OP_W-1:0]    sel_op;
   logic [DATA_W-1:0]  sel_a, sel_b, alu_result;

   // A slot is free when empty or being drained this cycle; no grants while in reset.
   assign eligible = i_req_valid & (~rsp_valid_q | i_rsp_ready) & {NUM_REQ{~i_reset}};

   alu_arbiter_rr_picker #(.N(NUM_REQ)) u_picker (
      .eligible_i (eligible),
      .ptr_i      (ptr_q),
      .grant_o    (grant),
      .idx_o      (grant_idx)
   );

   assign sel_op = i_req_op[32'(grant_idx) * OP_W +: OP_W];
   assign sel_a  = i_req_operandA[32'(grant_idx) * DATA_W +: DATA_W];
   assign sel_b  = i_req_operandB[32'(grant_idx) * DATA_W +: DATA_W];

   alu_arbiter_alu u_alu (
      .op_i     (sel_op),
      .a_i      (sel_a),
      .b_i      (sel_b),
      .result_o (alu_result)
   );

   assign accept      = |grant;
   assign o_req_ready = grant;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_result = rsp_result_q;

   always_comb begin
      rsp_valid_d  = rsp_valid_q & ~i_rsp_ready;
      rsp_result_d = rsp_result_q;
      ptr_d        = ptr_q;
      if (accept) begin
         rsp_valid_d[grant_idx]                          = 1'b1;
         rsp_result_d[32'(grant_idx) * DATA_W +: DATA_W] = alu_result;
         ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         ptr_q        <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         ptr_q        <= ptr_d;
      end
   end

endmodule
